// File: rtl/trdb_pkg.sv
// Shared trace-debug types and defaults for the branch map blocks.
package trdb_pkg;

    localparam int unsigned NRET_DEF = 2;

    typedef struct packed {
        logic valid;
        logic taken;
    } branch_lane_t;

endpackage

// File: rtl/trdb_lane_rank.sv
// Prefix-count of per-lane valid flags: rank of each lane among the valid ones, plus popcount.
module trdb_lane_rank #(
    parameter int unsigned NRET   = 2,
    parameter int unsigned RANK_W = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]             valid_i,
    output logic [NRET-1:0][RANK_W-1:0] rank_o,
    output logic [RANK_W-1:0]           total_o
);

    logic [RANK_W-1:0] acc;

    always_comb begin
        acc    = '0;
        rank_o = '0;
        for (int k = 0; k < NRET; k++) begin
            rank_o[k] = acc;
            acc       = acc + RANK_W'(valid_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/trdb_branch_map_mr.sv
// Multi-retirement branch map. Define TRDB_BRANCH_PRED_EN to add the branch-predictor
// compression front end (pred_i / pbc_o / mispred_o).
module trdb_branch_map_mr
    import trdb_pkg::*;
#(
    parameter int unsigned NRET    = NRET_DEF,
    parameter int unsigned MAP_LEN = 31,
    parameter int unsigned CNT_W   = $clog2(MAP_LEN + 1),
    parameter int unsigned PBC_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NRET-1:0]    valid_i,
    input  logic [NRET-1:0]    taken_i,
    input  logic               flush_i,
`ifdef TRDB_BRANCH_PRED_EN
    input  logic [NRET-1:0]    pred_i,
    output logic [PBC_W-1:0]   pbc_o,
    output logic               mispred_o,
`endif
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);

    localparam int unsigned RANK_W = $clog2(NRET + 1);

    logic [CNT_W-1:0]             base;
    logic [NRET-1:0]              ins_valid;
    logic [NRET-1:0][RANK_W-1:0]  rank;
    logic [RANK_W-1:0]            total;

    logic [MAP_LEN-1:0] map_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               full_n, empty_n, ovf_n;
    int unsigned        sum;

    assign base = flush_i ? '0 : branches_o;

`ifdef TRDB_BRANCH_PRED_EN
    logic [PBC_W-1:0] pbc_n;
    logic             mispred_n;
    logic             skipping;

    // While the map is empty, correctly predicted branches are only counted, not stored.
    always_comb begin
        pbc_n     = flush_i ? '0 : pbc_o;
        mispred_n = 1'b0;
        skipping  = (base == '0);
        ins_valid = valid_i;
        for (int k = 0; k < NRET; k++) begin
            if (valid_i[k] && skipping) begin
                if (taken_i[k] == pred_i[k]) begin
                    ins_valid[k] = 1'b0;
                    if (pbc_n != '1) pbc_n = pbc_n + 1'b1;
                end else begin
                    mispred_n = 1'b1;
                    skipping  = 1'b0;
                end
            end
        end
    end
`else
    assign ins_valid = valid_i;
`endif

    trdb_lane_rank #(
        .NRET   (NRET),
        .RANK_W (RANK_W)
    ) u_rank (
        .valid_i (ins_valid),
        .rank_o  (rank),
        .total_o (total)
    );

    always_comb begin
        map_n = flush_i ? '0 : map_o;
        for (int i = 0; i < int'(MAP_LEN); i++) begin
            for (int k = 0; k < int'(NRET); k++) begin
                if (ins_valid[k] && (int'(base) + int'(rank[k]) == i))
                    map_n[i] = ~taken_i[k];
            end
        end
        sum   = int'(base) + int'(total);
        ovf_n = (flush_i ? 1'b0 : overflow_o) | (sum > MAP_LEN);
        cnt_n = (sum > MAP_LEN) ? CNT_W'(MAP_LEN) : CNT_W'(sum);
        full_n  = (cnt_n == CNT_W'(MAP_LEN));
        empty_n = (cnt_n == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_o      <= '0;
            branches_o <= '0;
            is_full_o  <= 1'b0;
            is_empty_o <= 1'b1;
            overflow_o <= 1'b0;
`ifdef TRDB_BRANCH_PRED_EN
            pbc_o      <= '0;
            mispred_o  <= 1'b0;
`endif
        end else begin
            map_o      <= map_n;
            branches_o <= cnt_n;
            is_full_o  <= full_n;
            is_empty_o <= empty_n;
            overflow_o <= ovf_n;
`ifdef TRDB_BRANCH_PRED_EN
            pbc_o      <= pbc_n;
            mispred_o  <= mispred_n;
`endif
        end
    end

endmodule

// File: tb/tb_trdb_branch_map_mr.sv
// Bench for trdb_branch_map_mr (NRET=2, MAP_LEN=31); queue-style reference model plus directed vectors.
module tb_trdb_branch_map_mr;

    localparam int NRET    = 2;
    localparam int MAP_LEN = 31;
    localparam int CNT_W   = 5;
    localparam int PBC_W   = 16;

    logic               clk;
    logic               rst_n;
    logic [NRET-1:0]    valid;
    logic [NRET-1:0]    taken;
    logic               flush;
    logic [MAP_LEN-1:0] map_o;
    logic [CNT_W-1:0]   branches_o;
    logic               is_full_o, is_empty_o, overflow_o;
`ifdef TRDB_BRANCH_PRED_EN
    logic [NRET-1:0]    pred;
    logic [PBC_W-1:0]   pbc_o;
    logic               mispred_o;
`endif

    int checks = 0;
    int errors = 0;

    trdb_branch_map_mr #(.NRET(NRET), .MAP_LEN(MAP_LEN), .PBC_W(PBC_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid),
        .taken_i    (taken),
        .flush_i    (flush),
`ifdef TRDB_BRANCH_PRED_EN
        .pred_i     (pred),
        .pbc_o      (pbc_o),
        .mispred_o  (mispred_o),
`endif
        .map_o      (map_o),
        .branches_o (branches_o),
        .is_full_o  (is_full_o),
        .is_empty_o (is_empty_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: branches appended one by one, oldest lane first.
    int               m_cnt;
    bit [MAP_LEN-1:0] m_map;
    bit               m_ovf;
    int               m_pbc;
    bit               m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_map = '0; m_ovf = 0; m_pbc = 0; m_mis = 0;
        end else begin
            m_mis = 0;
            if (flush) begin
                m_cnt = 0; m_map = '0; m_ovf = 0; m_pbc = 0;
            end
            for (int k = 0; k < NRET; k++) begin
                if (valid[k]) begin
`ifdef TRDB_BRANCH_PRED_EN
                    if (m_cnt == 0 && taken[k] == pred[k]) begin
                        if (m_pbc < (1 << PBC_W) - 1) m_pbc++;
                        continue;
                    end
                    if (m_cnt == 0) m_mis = 1;
`endif
                    if (m_cnt < MAP_LEN) begin
                        m_map[m_cnt] = ~taken[k];
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("map", 64'(map_o), 64'(m_map));
        chk("branches", 64'(branches_o), 64'(m_cnt));
        chk("full", 64'(is_full_o), 64'(m_cnt == MAP_LEN));
        chk("empty", 64'(is_empty_o), 64'(m_cnt == 0));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
`ifdef TRDB_BRANCH_PRED_EN
        chk("pbc", 64'(pbc_o), 64'(m_pbc));
        chk("mispred", 64'(mispred_o), 64'(m_mis));
`endif
    end

    task automatic step(input logic [1:0] v, input logic [1:0] t, input logic f, input logic [1:0] p);
        valid = v; taken = t; flush = f;
`ifdef TRDB_BRANCH_PRED_EN
        pred = p;
`else
        if (p != 2'b00) valid = v;
`endif
        @(posedge clk);
        #2;
        valid = '0; taken = '0; flush = 1'b0;
    endtask

    logic [MAP_LEN-1:0] snap;

    initial begin
        rst_n = 1'b0; valid = '0; taken = '0; flush = 1'b0;
`ifdef TRDB_BRANCH_PRED_EN
        pred = '0;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        // reset state
        chk("t1_map", 64'(map_o), 64'h0);
        chk("t1_branches", 64'(branches_o), 64'h0);
        chk("t1_empty", 64'(is_empty_o), 64'h1);
        chk("t1_full", 64'(is_full_o), 64'h0);
        chk("t1_overflow", 64'(overflow_o), 64'h0);

`ifndef TRDB_BRANCH_PRED_EN
        // two lanes then one lane
        step(2'b11, 2'b01, 1'b0, 2'b00);
        step(2'b01, 2'b00, 1'b0, 2'b00);
        chk("t2_map", 64'(map_o[2:0]), 64'b110);
        chk("t2_branches", 64'(branches_o), 64'd3);

        // reach five, then flush with a lane-1-only branch
        step(2'b11, 2'b11, 1'b0, 2'b00);
        chk("t4_pre_branches", 64'(branches_o), 64'd5);
        chk("t4_pre_map", 64'(map_o), 64'b00110);
        step(2'b10, 2'b10, 1'b1, 2'b00);
        chk("t4_branches", 64'(branches_o), 64'd1);
        chk("t4_map", 64'(map_o), 64'h0);

        // fill from 1 to 30
        for (int i = 0; i < 14; i++) step(2'b11, 2'b10, 1'b0, 2'b00);
        step(2'b01, 2'b01, 1'b0, 2'b00);
        chk("t3_pre_branches", 64'(branches_o), 64'd30);
        chk("t3_pre_full", 64'(is_full_o), 64'h0);
        step(2'b11, 2'b00, 1'b0, 2'b00);
        chk("t3_branches", 64'(branches_o), 64'd31);
        chk("t3_full", 64'(is_full_o), 64'h1);
        chk("t3_overflow", 64'(overflow_o), 64'h1);
        chk("t3_bit30", 64'(map_o[30]), 64'h1);
        chk("t3_bit29", 64'(map_o[29]), 64'h0);

        // full: further branches dropped, map unchanged, overflow sticky
        snap = map_o;
        step(2'b11, 2'b00, 1'b0, 2'b00);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        chk("full_hold_map", 64'(map_o), 64'(snap));
        chk("full_hold_ovf", 64'(overflow_o), 64'h1);

        // flush alone
        step(2'b00, 2'b00, 1'b1, 2'b00);
        chk("t5_branches", 64'(branches_o), 64'd0);
        chk("t5_empty", 64'(is_empty_o), 64'h1);
        chk("t5_overflow", 64'(overflow_o), 64'h0);
        chk("t5_map", 64'(map_o), 64'h0);

        // invalid lane 0 with taken set is ignored
        step(2'b10, 2'b01, 1'b0, 2'b00);
        chk("lane1_only_map", 64'(map_o), 64'h1);
        chk("lane1_only_branches", 64'(branches_o), 64'd1);
`else
        // three correct predictions, then a mismatch (not taken)
        step(2'b11, 2'b11, 1'b0, 2'b11);
        step(2'b01, 2'b00, 1'b0, 2'b00);
        chk("t6_pbc_pre", 64'(pbc_o), 64'd3);
        chk("t6_empty_pre", 64'(is_empty_o), 64'h1);
        step(2'b01, 2'b00, 1'b0, 2'b01);
        chk("t6_pbc", 64'(pbc_o), 64'd3);
        chk("t6_mispred", 64'(mispred_o), 64'h1);
        chk("t6_map0", 64'(map_o[0]), 64'h1);
        chk("t6_branches", 64'(branches_o), 64'd1);
        step(2'b01, 2'b01, 1'b0, 2'b01);
        chk("t6_mispred_drop", 64'(mispred_o), 64'h0);
        chk("t6_after_branches", 64'(branches_o), 64'd2);
        step(2'b00, 2'b00, 1'b1, 2'b00);
        chk("t6_flush_pbc", 64'(pbc_o), 64'd0);
`endif

        // asynchronous reset mid-cycle
        step(2'b11, 2'b00, 1'b0, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_map", 64'(map_o), 64'h0);
        chk("arst_branches", 64'(branches_o), 64'h0);
        chk("arst_empty", 64'(is_empty_o), 64'h1);
        chk("arst_full", 64'(is_full_o), 64'h0);
        chk("arst_overflow", 64'(overflow_o), 64'h0);
`ifdef TRDB_BRANCH_PRED_EN
        chk("arst_pbc", 64'(pbc_o), 64'h0);
        chk("arst_mispred", 64'(mispred_o), 64'h0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;
        step(2'b01, 2'b00, 1'b0, 2'b01);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
